// File: rtl/keyed_lock_pkg.sv
// rtl/keyed_lock_pkg.sv - shared types and helpers for the keyed lock pipeline
package keyed_lock_pkg;

   // Upper bound on DATA_W and KEY_W that the helper functions can handle
   localparam int KL_MAX_W = 256;

   typedef enum logic [1:0] {
      KL_IDLE  = 2'd0,
      KL_LOAD  = 2'd1,
      KL_ARMED = 2'd2
   } kl_state_t;

   // Rotate the low w bits of v left by one; bits at and above w come back 0
   function automatic logic [KL_MAX_W-1:0] rotl(input logic [KL_MAX_W-1:0] v, input int w);
      logic [KL_MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < KL_MAX_W; i++) begin
         if (i < w) r[(i + 1) % w] = v[i];
      end
      return r;
   endfunction

   // Fold key/polarity mismatches onto data bits: bit j collects every k with k mod data_w == j
   function automatic logic [KL_MAX_W-1:0] key_mask(input int data_w, input int key_w,
                                                    input logic [KL_MAX_W-1:0] key,
                                                    input logic [KL_MAX_W-1:0] pol);
      logic [KL_MAX_W-1:0] m;
      m = '0;
      for (int k = 0; k < KL_MAX_W; k++) begin
         if (k < key_w) m[k % data_w] = m[k % data_w] ^ (key[k] ^ pol[k]);
      end
      return m;
   endfunction

endpackage

// File: rtl/keyed_lock_loader.sv
// rtl/keyed_lock_loader.sv - serial key loader: shadow shift, bit count, atomic commit and clear
module keyed_lock_loader
   import keyed_lock_pkg::*;
#(
   parameter int KEY_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_bit,
   input  logic             key_valid,
   input  logic             key_clear,
   output logic             key_ready,
   output logic             armed,
   output logic [KEY_W-1:0] act_key
);

   localparam int CNT_W = $clog2(KEY_W + 1);

   kl_state_t        state_q, state_d;
   logic [KEY_W-1:0] shadow_q;
   logic [KEY_W-1:0] shadow_shift;
   logic [CNT_W-1:0] cnt_q;
   logic             accept;
   logic             last_bit;

   assign accept   = key_valid & key_ready;
   assign last_bit = accept & (cnt_q == CNT_W'(KEY_W - 1));

   generate
      if (KEY_W == 1) begin : g_shift_one
         assign shadow_shift = key_bit;
      end else begin : g_shift_many
         assign shadow_shift = {shadow_q[KEY_W-2:0], key_bit};
      end
   endgenerate

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= KL_IDLE;
      else     state_q <= state_d;
   end

   // Next state: clear wins over everything, the final accepted bit arms the lock
   always_comb begin
      state_d = state_q;
      if (key_clear) begin
         state_d = KL_IDLE;
      end else begin
         case (state_q)
            KL_IDLE:  if (accept) state_d = last_bit ? KL_ARMED : KL_LOAD;
            KL_LOAD:  if (last_bit) state_d = KL_ARMED;
            KL_ARMED: state_d = KL_ARMED;
            default:  state_d = KL_IDLE;
         endcase
      end
   end

   // Outputs decoded from state alone
   always_comb begin
      key_ready = 1'b1;
      armed     = 1'b0;
      if (state_q == KL_ARMED) begin
         key_ready = 1'b0;
         armed     = 1'b1;
      end
   end

   // Shadow, counter and active key; the active key moves only on commit or clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q <= '0;
         cnt_q    <= '0;
         act_key  <= '0;
      end else if (key_clear) begin
         shadow_q <= '0;
         cnt_q    <= '0;
         act_key  <= '0;
      end else if (accept) begin
         shadow_q <= shadow_shift;
         if (last_bit) begin
            act_key <= shadow_shift;
            cnt_q   <= '0;
         end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/keyed_lock_pipe.sv
// rtl/keyed_lock_pipe.sv - key-gated mixing pipeline; optional KEY_LOCKOUT_EN suppresses output until armed
module keyed_lock_pipe
   import keyed_lock_pkg::*;
#(
   parameter int               DATA_W  = 8,
   parameter int               KEY_W   = 16,
   parameter int               STAGES  = 2,
   parameter logic [KEY_W-1:0] KEY_POL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_bit,
   input  logic              key_valid,
   output logic              key_ready,
   input  logic              key_clear,
   output logic              armed,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid
);

   logic [KEY_W-1:0]  act_key;
   logic [DATA_W-1:0] mask;
   logic [DATA_W-1:0] pd  [STAGES];
   logic [DATA_W-1:0] mix [STAGES];
   logic [STAGES-1:0] pv;
   logic              gate_in;
   logic              flush;

   keyed_lock_loader #(.KEY_W(KEY_W)) u_loader (
      .clk       (clk),
      .rst       (rst),
      .key_bit   (key_bit),
      .key_valid (key_valid),
      .key_clear (key_clear),
      .key_ready (key_ready),
      .armed     (armed),
      .act_key   (act_key)
   );

   // Key gates: zero mask only when the active key matches the polarity
   assign mask = DATA_W'(key_mask(DATA_W, KEY_W, KL_MAX_W'(act_key), KL_MAX_W'(KEY_POL)));

`ifdef KEY_LOCKOUT_EN
   assign gate_in = ~armed;
   assign flush   = key_clear;
`else
   assign gate_in = 1'b0;
   assign flush   = 1'b0;
`endif

   assign mix[0] = din ^ mask;

   generate
      for (genvar s = 1; s < STAGES; s++) begin : g_mix
         assign mix[s] = pd[s-1] ^ DATA_W'(rotl(KL_MAX_W'(pd[s-1]), DATA_W));
      end
   endgenerate

   // Pipeline registers: data loads every cycle, valid rides alongside
   always_ff @(posedge clk or posedge rst) begin
      if (rst || flush) begin
         for (int s = 0; s < STAGES; s++) pd[s] <= '0;
         pv <= '0;
      end else begin
         pd[0] <= gate_in ? '0 : mix[0];
         pv[0] <= gate_in ? 1'b0 : din_valid;
         for (int s = 1; s < STAGES; s++) begin
            pd[s] <= mix[s];
            pv[s] <= pv[s-1];
         end
      end
   end

   assign dout       = pd[STAGES-1];
   assign dout_valid = pv[STAGES-1];

endmodule

// File: tb/tb_keyed_lock_pipe.sv
// tb/tb_keyed_lock_pipe.sv - scoreboard bench driving one-stage and two-stage instances in lockstep
module tb_keyed_lock_pipe;

`ifdef KEY_LOCKOUT_EN
   localparam bit LOCKOUT = 1'b1;
`else
   localparam bit LOCKOUT = 1'b0;
`endif
   localparam logic [3:0] POL = 4'b1010;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       key_bit = 1'b0, key_valid = 1'b0, key_clear = 1'b0;
   logic [7:0] din = 8'h00;
   logic       din_valid = 1'b0;

   logic       key_ready1, armed1, dout_valid1;
   logic [7:0] dout1;
   logic       key_ready2, armed2, dout_valid2;
   logic [7:0] dout2;

   int total = 0;
   int bad   = 0;

   logic [7:0] q1[$];
   logic [7:0] q2[$];

   int         m_state = 0;
   logic [3:0] m_sh = '0;
   logic [3:0] m_key = '0;
   int         m_cnt = 0;

   always #5 clk = ~clk;

   keyed_lock_pipe #(.DATA_W(8), .KEY_W(4), .STAGES(1), .KEY_POL(POL)) u_dut1 (
      .clk(clk), .rst(rst), .key_bit(key_bit), .key_valid(key_valid), .key_ready(key_ready1),
      .key_clear(key_clear), .armed(armed1), .din(din), .din_valid(din_valid),
      .dout(dout1), .dout_valid(dout_valid1)
   );

   keyed_lock_pipe #(.DATA_W(8), .KEY_W(4), .STAGES(2), .KEY_POL(POL)) u_dut2 (
      .clk(clk), .rst(rst), .key_bit(key_bit), .key_valid(key_valid), .key_ready(key_ready2),
      .key_clear(key_clear), .armed(armed2), .din(din), .din_valid(din_valid),
      .dout(dout2), .dout_valid(dout_valid2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] stage1_exp(input logic [7:0] d, input logic [3:0] k);
      return d ^ {4'b0000, k ^ POL};
   endfunction

   function automatic logic [7:0] stage2_exp(input logic [7:0] x);
      return x ^ {x[6:0], x[7]};
   endfunction

   task automatic model_reset();
      m_state = 0;
      m_sh    = '0;
      m_key   = '0;
      m_cnt   = 0;
   endtask

   // One cycle: drive at posedge+1, model the edge, check key status after it
   task automatic step(input logic [7:0] d, input logic dv, input logic kb, input logic kv, input logic kc);
      logic [7:0] e;
      din = d; din_valid = dv; key_bit = kb; key_valid = kv; key_clear = kc;
      if (dv && (!LOCKOUT || (m_state == 2 && !kc))) begin
         e = stage1_exp(d, m_key);
         q1.push_back(e);
         q2.push_back(stage2_exp(e));
      end
      @(posedge clk);
      if (kc) begin
         model_reset();
         if (LOCKOUT) begin
            q1.delete();
            q2.delete();
         end
      end else if (kv && m_state != 2) begin
         m_sh = {m_sh[2:0], kb};
         if (m_cnt == 3) begin
            m_key   = m_sh;
            m_cnt   = 0;
            m_state = 2;
         end else begin
            m_cnt++;
            m_state = 1;
         end
      end
      #1;
      check("armed1", 32'(armed1), 32'(m_state == 2));
      check("key_ready1", 32'(key_ready1), 32'(m_state != 2));
      check("armed2", 32'(armed2), 32'(m_state == 2));
   endtask

   task automatic load4(input logic [3:0] k);
      for (int i = 3; i >= 0; i--) step(8'($urandom), 1'b1, k[i], 1'b1, 1'b0);
   endtask

   // Scoreboard consumer
   always @(negedge clk) begin
      if (!rst) begin
         if (dout_valid1) begin
            if (q1.size() == 0) check("dout1_unexpected", 32'(dout1), 32'hFFFF_FFFF);
            else check("dout1", 32'(dout1), 32'(q1.pop_front()));
         end
         if (dout_valid2) begin
            if (q2.size() == 0) check("dout2_unexpected", 32'(dout2), 32'hFFFF_FFFF);
            else check("dout2", 32'(dout2), 32'(q2.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 rst = 1'b1;
      #1;
      check("rst_dout1", 32'(dout1), 0);
      check("rst_dv1", 32'(dout_valid1), 0);
      check("rst_armed1", 32'(armed1), 0);
      check("rst_ready1", 32'(key_ready1), 1);
      check("rst_dout2", 32'(dout2), 0);
      check("rst_dv2", 32'(dout_valid2), 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // Wrong (zero) key: 00 -> 0A
      step(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      // Correct key 1010 then pass-through
      load4(4'b1010);
      step(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
      step(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
      // Wrong key 1011: 5A -> 5B
      step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      load4(4'b1011);
      step(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
      // Load with a gap: partial load must not perturb the datapath
      step(8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
      step(8'h22, 1'b1, 1'b1, 1'b1, 1'b0);
      step(8'h33, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(8'h44 + 8'(i), 1'b1, 1'b1, 1'b0, 1'b0);
      step(8'h55, 1'b1, 1'b1, 1'b1, 1'b0);
      step(8'h66, 1'b1, 1'b0, 1'b1, 1'b0);
      step(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
      // Clear together with a key bit: bit dropped, relocked
      step(8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
      step(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      step(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      // Fresh full load proves the counter restarted at zero
      load4(4'b1010);
      step(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
      step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(8'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0);

      // Asynchronous reset mid-stream
      step(8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      check("mid_rst_dout1", 32'(dout1), 0);
      check("mid_rst_dv1", 32'(dout_valid1), 0);
      check("mid_rst_dout2", 32'(dout2), 0);
      check("mid_rst_dv2", 32'(dout_valid2), 0);
      check("mid_rst_armed", 32'(armed2), 0);
      check("mid_rst_ready", 32'(key_ready2), 1);
      q1.delete();
      q2.delete();
      model_reset();
      din_valid = 1'b0;
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;
      step(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      step(8'h7E, 1'b1, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 4; i++) step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      check("q1_drained", 32'(q1.size()), 0);
      check("q2_drained", 32'(q2.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
